// File: rtl/rx_deescaper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_deescaper_pkg
//  Description : Shared lane-escape definitions. The control characters,
//                word width and lane count match the TX escaper. Also holds
//                the SYNC word field positions and the state encodings of
//                the RX decode and lock FSMs.
//  Revision    : 1.0  initial release
// ============================================================================
package rx_deescaper_pkg;

   localparam int UNITWIDTH  = 16;
   localparam int LANENUMBER = 4;

   // SYNC word layout, LSB first: blocklock, 4 reserved bits, lane id, SYNC_CHAR
   localparam int SYNC_RSVD_LSB   = LANENUMBER;
   localparam int SYNC_LANEID_LSB = SYNC_RSVD_LSB + 4;
   localparam int SYNC_CHAR_LSB   = SYNC_LANEID_LSB + 3;
   localparam int SYNC_CHAR_W     = UNITWIDTH - SYNC_CHAR_LSB;

   localparam logic [UNITWIDTH-1:0]   ESC_CHAR  = 16'h007D;
   localparam logic [UNITWIDTH-1:0]   IDLE_CHAR = 16'h0069;
   localparam logic [SYNC_CHAR_W-1:0] SYNC_CHAR = 5'h16;

   typedef enum logic [0:0] {
      DEC_NORMAL   = 1'b0,
      DEC_ESC_SEEN = 1'b1
   } dec_state_t;

   typedef enum logic [1:0] {
      LOCK_UNLOCKED = 2'd0,
      LOCK_LOCKING  = 2'd1,
      LOCK_LOCKED   = 2'd2
   } lock_state_t;

   // Builds the second word of a SYNC escape pair
   function automatic logic [UNITWIDTH-1:0] make_sync(input logic [2:0]            lane,
                                                      input logic [3:0]            rsvd,
                                                      input logic [LANENUMBER-1:0] blocklock);
      return {SYNC_CHAR, lane, rsvd, blocklock};
   endfunction

endpackage
`default_nettype wire

// File: rtl/rx_sync_lock_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : rx_sync_lock_fsm
//  Description : Lane lock tracker. Consecutive good SYNCs acquire lock;
//                a run of escape errors with no good SYNC in between drops
//                it. Both counters saturate.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_sync_lock_fsm
   import rx_deescaper_pkg::*;
#(
   parameter int SYNC_LOCK_CNT  = 4,
   parameter int ERR_UNLOCK_CNT = 8
)(
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic good_sync,
   input  logic bad_sync,
   input  logic esc_err,
   output logic locked
);

   localparam int GW = $clog2(SYNC_LOCK_CNT + 1);
   localparam int EW = $clog2(ERR_UNLOCK_CNT + 1);
   localparam logic [GW-1:0] c_good_max = GW'(SYNC_LOCK_CNT);
   localparam logic [EW-1:0] c_err_max  = EW'(ERR_UNLOCK_CNT);

   lock_state_t   r_state;
   logic [GW-1:0] r_good_cnt;
   logic [EW-1:0] r_err_cnt;
   logic [GW-1:0] w_good_next;
   logic [EW-1:0] w_err_next;

   assign w_good_next = (r_good_cnt == c_good_max) ? r_good_cnt : r_good_cnt + GW'(1);
   assign w_err_next  = (r_err_cnt  == c_err_max)  ? r_err_cnt  : r_err_cnt  + EW'(1);

   // Lock state, saturating counters and the registered lock indication
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= LOCK_UNLOCKED;
         r_good_cnt <= '0;
         r_err_cnt  <= '0;
         locked     <= 1'b0;
      end else begin
         locked <= (r_state == LOCK_LOCKED);
         if (enable) begin
            if (good_sync) begin
               r_good_cnt <= w_good_next;
               r_err_cnt  <= '0;
               case (r_state)
                  LOCK_UNLOCKED: r_state <= (w_good_next == c_good_max) ? LOCK_LOCKED : LOCK_LOCKING;
                  LOCK_LOCKING:  if (w_good_next == c_good_max) r_state <= LOCK_LOCKED;
                  LOCK_LOCKED:   r_state <= LOCK_LOCKED;
                  default:       r_state <= LOCK_UNLOCKED;
               endcase
            end else if (bad_sync) begin
               // A foreign lane id only matters while lock is still being built
               if (r_state != LOCK_LOCKED) begin
                  r_good_cnt <= '0;
                  r_state    <= LOCK_UNLOCKED;
               end
            end else if (esc_err) begin
               r_err_cnt  <= w_err_next;
               r_good_cnt <= '0;
               case (r_state)
                  LOCK_LOCKING: r_state <= LOCK_UNLOCKED;
                  LOCK_LOCKED:  if (w_err_next == c_err_max) r_state <= LOCK_UNLOCKED;
                  default:      r_state <= LOCK_UNLOCKED;
               endcase
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rx_deescaper.sv
`default_nettype none
// ============================================================================
//  Module      : rx_deescaper
//  Description : Per-lane RX escape decoder. Passes user data (including
//                doubled ESC_CHAR), drops IDLE pairs, decodes SYNC pairs
//                into remote lane id / blocklock, and tracks SYNC lock.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_deescaper
   import rx_deescaper_pkg::*;
#(
   parameter int SYNC_LOCK_CNT  = 4,
   parameter int ERR_UNLOCK_CNT = 8
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_enable,
   input  logic [2:0]            in_lane_id,
   input  logic                  in_rxdata_en,
   input  logic [UNITWIDTH-1:0]  in_rxdata,
   output logic                  out_rxdata_en,
   output logic [UNITWIDTH-1:0]  out_rxdata,
   output logic                  out_rxsync,
   output logic                  out_idle_rcvd,
   output logic                  out_escape_error,
   output logic [2:0]            out_remote_lane_id,
   output logic [LANENUMBER-1:0] out_remote_blocklock,
   output logic                  out_lane_id_mismatch,
   output logic                  out_sync_locked
);

   dec_state_t r_dec_state;

   logic                   w_consume;
   logic                   w_second;
   logic                   w_is_esc;
   logic                   w_is_idle;
   logic                   w_sync_wf;
   logic                   w_lane_match;
   logic [SYNC_CHAR_W-1:0] w_sync_char;
   logic [2:0]             w_sync_lane;
   logic [3:0]             w_sync_rsvd;
   logic [LANENUMBER-1:0]  w_sync_bl;
   logic                   w_good_sync;
   logic                   w_bad_sync;
   logic                   w_esc_err;

   assign w_consume    = in_enable & in_rxdata_en;
   assign w_second     = w_consume & (r_dec_state == DEC_ESC_SEEN);
   assign w_is_esc     = (in_rxdata == ESC_CHAR);
   assign w_is_idle    = (in_rxdata == IDLE_CHAR);
   assign w_sync_char  = in_rxdata[UNITWIDTH-1:SYNC_CHAR_LSB];
   assign w_sync_lane  = in_rxdata[SYNC_CHAR_LSB-1:SYNC_LANEID_LSB];
   assign w_sync_rsvd  = in_rxdata[SYNC_LANEID_LSB-1:SYNC_RSVD_LSB];
   assign w_sync_bl    = in_rxdata[SYNC_RSVD_LSB-1:0];
   assign w_sync_wf    = (w_sync_char == SYNC_CHAR) && (w_sync_rsvd == 4'b0000);
   assign w_lane_match = (w_sync_lane == in_lane_id);

   // Events for the lock tracker, valid only on the second word of a pair
   assign w_good_sync = w_second & ~w_is_esc & ~w_is_idle &  w_sync_wf &  w_lane_match;
   assign w_bad_sync  = w_second & ~w_is_esc & ~w_is_idle &  w_sync_wf & ~w_lane_match;
   assign w_esc_err   = w_second & ~w_is_esc & ~w_is_idle & ~w_sync_wf;

   // Escape decode FSM with registered data, pulse and SYNC-field outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dec_state          <= DEC_NORMAL;
         out_rxdata_en        <= 1'b0;
         out_rxdata           <= '0;
         out_rxsync           <= 1'b0;
         out_idle_rcvd        <= 1'b0;
         out_escape_error     <= 1'b0;
         out_remote_lane_id   <= '0;
         out_remote_blocklock <= '0;
         out_lane_id_mismatch <= 1'b0;
      end else begin
         out_rxdata_en    <= 1'b0;
         out_rxsync       <= 1'b0;
         out_idle_rcvd    <= 1'b0;
         out_escape_error <= 1'b0;
         if (w_consume) begin
            case (r_dec_state)
               DEC_NORMAL: begin
                  if (w_is_esc) begin
                     r_dec_state <= DEC_ESC_SEEN;
                  end else begin
                     out_rxdata_en <= 1'b1;
                     out_rxdata    <= in_rxdata;
                  end
               end
               DEC_ESC_SEEN: begin
                  r_dec_state <= DEC_NORMAL;
                  if (w_is_esc) begin
                     out_rxdata_en <= 1'b1;
                     out_rxdata    <= ESC_CHAR;
                  end else if (w_is_idle) begin
                     out_idle_rcvd <= 1'b1;
                  end else if (w_sync_wf) begin
                     out_remote_lane_id   <= w_sync_lane;
                     out_remote_blocklock <= w_sync_bl;
                     out_lane_id_mismatch <= ~w_lane_match;
                     out_rxsync           <= w_lane_match;
                  end else begin
                     out_escape_error <= 1'b1;
                  end
               end
               default: r_dec_state <= DEC_NORMAL;
            endcase
         end
      end
   end

   rx_sync_lock_fsm #(
      .SYNC_LOCK_CNT  (SYNC_LOCK_CNT),
      .ERR_UNLOCK_CNT (ERR_UNLOCK_CNT)
   ) u_lock (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (in_enable),
      .good_sync (w_good_sync),
      .bad_sync  (w_bad_sync),
      .esc_err   (w_esc_err),
      .locked    (out_sync_locked)
   );

endmodule
`default_nettype wire

// File: tb/tb_rx_deescaper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_deescaper
//  Description : Directed self-checking bench for rx_deescaper.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rx_deescaper;
   import rx_deescaper_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  in_enable = 1'b1;
   logic [2:0]            in_lane_id = 3'd2;
   logic                  in_rxdata_en = 1'b0;
   logic [UNITWIDTH-1:0]  in_rxdata = '0;
   logic                  out_rxdata_en;
   logic [UNITWIDTH-1:0]  out_rxdata;
   logic                  out_rxsync;
   logic                  out_idle_rcvd;
   logic                  out_escape_error;
   logic [2:0]            out_remote_lane_id;
   logic [LANENUMBER-1:0] out_remote_blocklock;
   logic                  out_lane_id_mismatch;
   logic                  out_sync_locked;

   int errors = 0;
   int checks = 0;
   int step   = 0;

   typedef struct packed {
      logic                 en;
      logic [UNITWIDTH-1:0] data;
      logic                 sync;
      logic                 idle;
      logic                 err;
   } exp_t;

   exp_t sb[$];

   rx_deescaper dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .in_enable            (in_enable),
      .in_lane_id           (in_lane_id),
      .in_rxdata_en         (in_rxdata_en),
      .in_rxdata            (in_rxdata),
      .out_rxdata_en        (out_rxdata_en),
      .out_rxdata           (out_rxdata),
      .out_rxsync           (out_rxsync),
      .out_idle_rcvd        (out_idle_rcvd),
      .out_escape_error     (out_escape_error),
      .out_remote_lane_id   (out_remote_lane_id),
      .out_remote_blocklock (out_remote_blocklock),
      .out_lane_id_mismatch (out_lane_id_mismatch),
      .out_sync_locked      (out_sync_locked)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t mk(input logic en, input logic [UNITWIDTH-1:0] d,
                               input logic s, input logic i, input logic r);
      exp_t e;
      e.en = en; e.data = d; e.sync = s; e.idle = i; e.err = r;
      return e;
   endfunction

   function automatic exp_t e_none();        return mk(1'b0, '0, 1'b0, 1'b0, 1'b0); endfunction
   function automatic exp_t e_data(input logic [UNITWIDTH-1:0] d); return mk(1'b1, d, 1'b0, 1'b0, 1'b0); endfunction
   function automatic exp_t e_sync();        return mk(1'b0, '0, 1'b1, 1'b0, 1'b0); endfunction
   function automatic exp_t e_idle();        return mk(1'b0, '0, 1'b0, 1'b1, 1'b0); endfunction
   function automatic exp_t e_err();         return mk(1'b0, '0, 1'b0, 1'b0, 1'b1); endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // One clock: drive at negedge, push expectation, compare 1 ns after the edge
   task automatic cyc(input logic en, input logic v, input logic [UNITWIDTH-1:0] w, input exp_t e);
      exp_t x;
      @(negedge clk);
      in_enable    = en;
      in_rxdata_en = v;
      in_rxdata    = w;
      sb.push_back(e);
      @(posedge clk);
      #1;
      step++;
      x = sb.pop_front();
      chk($sformatf("rxdata_en#%0d", step),   32'(out_rxdata_en),    32'(x.en));
      chk($sformatf("rxsync#%0d", step),      32'(out_rxsync),       32'(x.sync));
      chk($sformatf("idle_rcvd#%0d", step),   32'(out_idle_rcvd),    32'(x.idle));
      chk($sformatf("esc_error#%0d", step),   32'(out_escape_error), 32'(x.err));
      if (x.en) chk($sformatf("rxdata#%0d", step), 32'(out_rxdata), 32'(x.data));
   endtask

   task automatic send(input logic [UNITWIDTH-1:0] w, input exp_t e);
      cyc(1'b1, 1'b1, w, e);
   endtask

   task automatic gap();
      cyc(1'b1, 1'b0, '0, e_none());
   endtask

   task automatic good_sync_pair();
      send(ESC_CHAR, e_none());
      send(make_sync(3'd2, 4'h0, 4'hF), e_sync());
   endtask

   task automatic err_pair();
      send(ESC_CHAR, e_none());
      send(16'h0000, e_err());
   endtask

   initial begin
      // ---- reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rxdata_en", 32'(out_rxdata_en), 0);
      chk("rst_rxdata",    32'(out_rxdata), 0);
      chk("rst_rxsync",    32'(out_rxsync), 0);
      chk("rst_idle",      32'(out_idle_rcvd), 0);
      chk("rst_err",       32'(out_escape_error), 0);
      chk("rst_rlane",     32'(out_remote_lane_id), 0);
      chk("rst_rbl",       32'(out_remote_blocklock), 0);
      chk("rst_mismatch",  32'(out_lane_id_mismatch), 0);
      chk("rst_locked",    32'(out_sync_locked), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // ---- data pass-through and doubled ESC
      send(16'h005A, e_data(16'h005A));
      send(ESC_CHAR, e_none());
      send(ESC_CHAR, e_data(ESC_CHAR));
      send(16'h0033, e_data(16'h0033));

      // ---- IDLE pairs, one straddling a gap
      send(ESC_CHAR, e_none());
      send(IDLE_CHAR, e_idle());
      gap(); gap(); gap();
      send(ESC_CHAR, e_none());
      gap();
      send(IDLE_CHAR, e_idle());

      // ---- acquire lock with 4 good SYNCs
      for (int i = 0; i < 4; i++) begin
         good_sync_pair();
         chk($sformatf("locked_acq%0d", i), 32'(out_sync_locked), 0);
      end
      chk("rlane_good",    32'(out_remote_lane_id), 2);
      chk("rbl_good",      32'(out_remote_blocklock), 32'hF);
      chk("mismatch_good", 32'(out_lane_id_mismatch), 0);
      gap();
      chk("locked_after4", 32'(out_sync_locked), 1);

      // ---- 8 escape errors drop lock
      for (int i = 0; i < 7; i++) err_pair();
      gap();
      chk("locked_err7", 32'(out_sync_locked), 1);
      err_pair();
      gap();
      chk("locked_err8", 32'(out_sync_locked), 0);

      // ---- relock, then a good SYNC after the 7th error restarts the count
      for (int i = 0; i < 4; i++) good_sync_pair();
      gap();
      chk("relocked", 32'(out_sync_locked), 1);
      for (int i = 0; i < 7; i++) err_pair();
      good_sync_pair();
      err_pair();
      gap();
      chk("held_after_sync", 32'(out_sync_locked), 1);
      for (int i = 0; i < 6; i++) err_pair();
      gap();
      chk("held_err7_again", 32'(out_sync_locked), 1);
      err_pair();
      gap();
      chk("drop_err8_again", 32'(out_sync_locked), 0);

      // ---- mismatched lane id and malformed SYNC
      send(ESC_CHAR, e_none());
      send(make_sync(3'd5, 4'h0, 4'hA), e_none());
      chk("mismatch_flag", 32'(out_lane_id_mismatch), 1);
      chk("mismatch_lane", 32'(out_remote_lane_id), 5);
      chk("mismatch_bl",   32'(out_remote_blocklock), 32'hA);
      send(ESC_CHAR, e_none());
      send(make_sync(3'd2, 4'h1, 4'hF), e_err());
      chk("rsvd_lane_kept", 32'(out_remote_lane_id), 5);

      // ---- reset right after an ESC while locked
      for (int i = 0; i < 4; i++) good_sync_pair();
      gap();
      chk("locked_pre_rst", 32'(out_sync_locked), 1);
      send(ESC_CHAR, e_none());
      @(negedge clk);
      in_rxdata_en = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("midrst_locked", 32'(out_sync_locked), 0);
      chk("midrst_rlane",  32'(out_remote_lane_id), 0);
      chk("midrst_rxdata", 32'(out_rxdata), 0);
      @(negedge clk);
      reset_n = 1'b1;
      send(16'h0011, e_data(16'h0011));

      // ---- in_enable low holds everything, including a pending ESC
      for (int i = 0; i < 4; i++) good_sync_pair();
      gap();
      chk("locked_pre_en", 32'(out_sync_locked), 1);
      send(ESC_CHAR, e_none());
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 16'h0000, e_none());
         chk($sformatf("en_locked%0d", i), 32'(out_sync_locked), 1);
         chk($sformatf("en_rlane%0d", i),  32'(out_remote_lane_id), 2);
         chk($sformatf("en_rxdata%0d", i), 32'(out_rxdata), 32'h0011);
      end
      send(ESC_CHAR, e_data(ESC_CHAR));
      gap();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
